// File: rtl/prog_lut_sweep_if.sv
// Bus bundle for prog_lut_sweep: lookup, table-write and sweep-stream signals.
// The master drives lookup/write/start; the slave (the LUT block) drives results.
interface prog_lut_sweep_if #(
    parameter int unsigned N_IN = 4
);
    logic [N_IN-1:0] in_vec;
    logic            f;
    logic            wr_en;
    logic [N_IN-1:0] wr_addr;
    logic            wr_data;
    logic            start;
    logic            busy;
    logic            sweep_valid;
    logic [N_IN-1:0] sweep_idx;
    logic            sweep_f;
    logic            done;
    logic [N_IN:0]   ones_count;

    modport master (
        output in_vec, wr_en, wr_addr, wr_data, start,
        input  f, busy, sweep_valid, sweep_idx, sweep_f, done, ones_count
    );

    modport slave (
        input  in_vec, wr_en, wr_addr, wr_data, start,
        output f, busy, sweep_valid, sweep_idx, sweep_f, done, ones_count
    );
endinterface

// File: rtl/prog_lut_sweep.sv
// Programmable N-input LUT with registered lookup and an exhaustive sweep engine
// that streams every (index, f) pair and counts the minterms where f=1.
module prog_lut_sweep #(
    parameter int unsigned N_IN       = 4,
    parameter              TABLE_INIT = 16'hCAFA
) (
    input  logic            clk,
    input  logic            rst,
    prog_lut_sweep_if.slave bus
);
    localparam int unsigned   DEPTH    = 1 << N_IN;
    localparam int unsigned   CW       = N_IN + 1;
    localparam logic [DEPTH-1:0] INIT_TBL = DEPTH'(TABLE_INIT);
    localparam logic [N_IN-1:0]  LAST_IDX = N_IN'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [DEPTH-1:0] tbl;
    logic             f_q;
    logic             busy_q;
    logic             valid_q;
    logic [N_IN-1:0]  idx;
    logic             done_q;
    logic [CW-1:0]    ones_q;

    // Table, lookup register and sweep FSM; the table only accepts writes in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            tbl     <= INIT_TBL;
            f_q     <= 1'b0;
            state   <= ST_IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            idx     <= '0;
            done_q  <= 1'b0;
            ones_q  <= '0;
        end else begin
            f_q    <= tbl[bus.in_vec];
            done_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (bus.wr_en) begin
                        tbl[bus.wr_addr] <= bus.wr_data;
                    end
                    if (bus.start) begin
                        state   <= ST_RUN;
                        idx     <= '0;
                        ones_q  <= '0;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    ones_q <= ones_q + CW'(tbl[idx]);
                    if (idx == LAST_IDX) begin
                        state   <= ST_DONE;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        idx <= idx + N_IN'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // sweep_f is a decode of the table and index registers, so it tracks writes in IDLE.
    assign bus.f           = f_q;
    assign bus.busy        = busy_q;
    assign bus.sweep_valid = valid_q;
    assign bus.sweep_idx   = idx;
    assign bus.sweep_f     = tbl[idx];
    assign bus.done        = done_q;
    assign bus.ones_count  = ones_q;
endmodule

// File: tb/tb_prog_lut_sweep.sv
// Directed self-checking bench for prog_lut_sweep with the default 16'hCAFA table.
module tb_prog_lut_sweep;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    prog_lut_sweep_if #(.N_IN(4)) bus ();

    prog_lut_sweep #(.N_IN(4), .TABLE_INIT(16'hCAFA)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(negedge clk);
    endtask

    // Advance until done is seen or the cycle budget runs out.
    task automatic run_to_done(output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_vec = '0; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = 1'b0; bus.start = 1'b0;
        step(); step();
        rst = 1'b0;
        checks++; if (bus.f !== 1'b0) begin errors++; $display("FAIL reset_f: got %b want 0", bus.f); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
        checks++; if (bus.sweep_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.sweep_valid); end
        checks++; if (bus.ones_count !== 5'd0) begin errors++; $display("FAIL reset_ones: got %0d want 0", bus.ones_count); end
        checks++; if (bus.sweep_idx !== 4'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", bus.sweep_idx); end
        bus.in_vec = 4'b0001; step();
        checks++; if (bus.f !== 1'b1) begin errors++; $display("FAIL lookup_0001: got %b want 1", bus.f); end
        bus.in_vec = 4'b1100; step();
        checks++; if (bus.f !== 1'b0) begin errors++; $display("FAIL lookup_1100: got %b want 0", bus.f); end
        bus.in_vec = 4'b1110; step();
        checks++; if (bus.f !== 1'b1) begin errors++; $display("FAIL lookup_1110: got %b want 1", bus.f); end
    endtask

    task automatic test_read_before_write();
        bus.in_vec = 4'd5; bus.wr_en = 1'b1; bus.wr_addr = 4'd5; bus.wr_data = 1'b0;
        step();
        bus.wr_en = 1'b0;
        checks++; if (bus.f !== 1'b1) begin errors++; $display("FAIL rbw_old: got %b want 1", bus.f); end
        step();
        checks++; if (bus.f !== 1'b0) begin errors++; $display("FAIL rbw_new: got %b want 0", bus.f); end
        bus.wr_en = 1'b1; bus.wr_data = 1'b1;
        step();
        bus.wr_en = 1'b0;
        step();
        checks++; if (bus.f !== 1'b1) begin errors++; $display("FAIL rbw_restore: got %b want 1", bus.f); end
    endtask

    task automatic test_default_sweep();
        logic [15:0] exp_tbl;
        exp_tbl = 16'hCAFA;
        bus.start = 1'b1; step(); bus.start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checks++; if (bus.sweep_valid !== 1'b1 || bus.busy !== 1'b1) begin
                errors++; $display("FAIL dflt_valid_busy[%0d]: got %b%b want 11", i, bus.sweep_valid, bus.busy); end
            checks++; if (bus.sweep_idx !== 4'(i)) begin
                errors++; $display("FAIL dflt_idx[%0d]: got %0d want %0d", i, bus.sweep_idx, i); end
            checks++; if (bus.sweep_f !== exp_tbl[i]) begin
                errors++; $display("FAIL dflt_f[%0d]: got %b want %b", i, bus.sweep_f, exp_tbl[i]); end
            step();
        end
        checks++; if (bus.done !== 1'b1 || bus.sweep_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL dflt_done_cycle: got done=%b valid=%b busy=%b want 1 0 0", bus.done, bus.sweep_valid, bus.busy); end
        checks++; if (bus.ones_count !== 5'd10) begin errors++; $display("FAIL dflt_ones: got %0d want 10", bus.ones_count); end
        step();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL dflt_done_pulse: got %b want 0", bus.done); end
        checks++; if (bus.ones_count !== 5'd10) begin errors++; $display("FAIL dflt_ones_hold: got %0d want 10", bus.ones_count); end
    endtask

    task automatic test_reprogram();
        logic [15:0] exp_tbl;
        exp_tbl = 16'hDAF8;
        bus.wr_en = 1'b1; bus.wr_addr = 4'b1100; bus.wr_data = 1'b1; step();
        bus.wr_addr = 4'b0001; bus.wr_data = 1'b0; step();
        bus.wr_en = 1'b0;
        bus.start = 1'b1; step(); bus.start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checks++; if (bus.sweep_f !== exp_tbl[i]) begin
                errors++; $display("FAIL reprog_f[%0d]: got %b want %b", i, bus.sweep_f, exp_tbl[i]); end
            step();
        end
        checks++; if (bus.done !== 1'b1 || bus.ones_count !== 5'd10) begin
            errors++; $display("FAIL reprog_ones: got done=%b ones=%0d want 1 10", bus.done, bus.ones_count); end
        bus.in_vec = 4'b1100; step();
        checks++; if (bus.f !== 1'b1) begin errors++; $display("FAIL reprog_f_1100: got %b want 1", bus.f); end
        bus.in_vec = 4'b0001; step();
        checks++; if (bus.f !== 1'b0) begin errors++; $display("FAIL reprog_f_0001: got %b want 0", bus.f); end
    endtask

    task automatic test_frozen();
        bit seen;
        bus.start = 1'b1; step(); bus.start = 1'b0;
        bus.wr_en = 1'b1; bus.wr_addr = 4'd0; bus.wr_data = 1'b1;
        checks++; if (bus.sweep_idx !== 4'd0 || bus.sweep_f !== 1'b0) begin
            errors++; $display("FAIL frozen_idx0: got idx=%0d f=%b want 0 0", bus.sweep_idx, bus.sweep_f); end
        step();
        run_to_done(seen);
        checks++; if (!seen || bus.ones_count !== 5'd10) begin
            errors++; $display("FAIL frozen_ones: got seen=%b ones=%0d want 1 10", seen, bus.ones_count); end
        bus.wr_en = 1'b0; bus.in_vec = 4'd0;
        step();
        checks++; if (bus.f !== 1'b0) begin errors++; $display("FAIL frozen_tbl0: got %b want 0", bus.f); end
    endtask

    task automatic test_same_edge_write_start();
        bit seen;
        bus.in_vec = 4'd0;
        bus.start = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 4'd0; bus.wr_data = 1'b1;
        step();
        bus.start = 1'b0; bus.wr_en = 1'b0;
        checks++; if (bus.sweep_idx !== 4'd0 || bus.sweep_f !== 1'b1) begin
            errors++; $display("FAIL same_edge_idx0: got idx=%0d f=%b want 0 1", bus.sweep_idx, bus.sweep_f); end
        run_to_done(seen);
        checks++; if (!seen || bus.ones_count !== 5'd11) begin
            errors++; $display("FAIL same_edge_ones: got seen=%b ones=%0d want 1 11", seen, bus.ones_count); end
        step();
        checks++; if (bus.f !== 1'b1) begin errors++; $display("FAIL same_edge_tbl0: got %b want 1", bus.f); end
    endtask

    task automatic test_reset_mid_sweep();
        bit found;
        bit seen;
        found = 1'b0;
        bus.start = 1'b1; step(); bus.start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (bus.sweep_idx === 4'd7 && bus.sweep_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
            step();
        end
        checks++; if (!found) begin errors++; $display("FAIL mid_reach_idx7: got %b want 1", found); end
        rst = 1'b1; step(); rst = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.sweep_valid !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL mid_ctrl: got busy=%b valid=%b done=%b want 0 0 0", bus.busy, bus.sweep_valid, bus.done); end
        checks++; if (bus.ones_count !== 5'd0) begin errors++; $display("FAIL mid_ones: got %0d want 0", bus.ones_count); end
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (bus.done === 1'b1) seen = 1'b1;
            step();
        end
        checks++; if (seen) begin errors++; $display("FAIL mid_no_done: got %b want 0", seen); end
        bus.in_vec = 4'd0; step();
        checks++; if (bus.f !== 1'b0) begin errors++; $display("FAIL mid_tbl0: got %b want 0", bus.f); end
        bus.in_vec = 4'b1100; step();
        checks++; if (bus.f !== 1'b0) begin errors++; $display("FAIL mid_tbl12: got %b want 0", bus.f); end
        bus.in_vec = 4'b0001; step();
        checks++; if (bus.f !== 1'b1) begin errors++; $display("FAIL mid_tbl1: got %b want 1", bus.f); end
    endtask

    task automatic test_start_held();
        bit seen;
        int p;
        bus.start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            step();
            p = (c - 1) % 18;
            checks++; if (bus.sweep_valid !== (p < 16) || bus.done !== (p == 16)) begin
                errors++; $display("FAIL held_ctrl[%0d]: got valid=%b done=%b want %b %b", c, bus.sweep_valid, bus.done, p < 16, p == 16); end
            if (p < 16) begin
                checks++; if (bus.sweep_idx !== 4'(p)) begin
                    errors++; $display("FAIL held_idx[%0d]: got %0d want %0d", c, bus.sweep_idx, p); end
            end
            if (c == 17 || c == 35 || c == 18) begin
                checks++; if (bus.ones_count !== 5'd10) begin
                    errors++; $display("FAIL held_ones[%0d]: got %0d want 10", c, bus.ones_count); end
            end
            if (c == 19) begin
                checks++; if (bus.ones_count !== 5'd0) begin
                    errors++; $display("FAIL held_ones_clr: got %0d want 0", bus.ones_count); end
            end
        end
        bus.start = 1'b0;
        run_to_done(seen);
        step(); step();
    endtask

    task automatic test_back_to_back();
        bus.start = 1'b1; step(); bus.start = 1'b0;
        for (int c = 1; c <= 19; c++) begin
            checks++; if (bus.sweep_valid !== (c <= 16) || bus.done !== (c == 17)) begin
                errors++; $display("FAIL b2b_ctrl[%0d]: got valid=%b done=%b want %b %b", c, bus.sweep_valid, bus.done, c <= 16, c == 17); end
            if (c <= 16) begin
                checks++; if (bus.sweep_idx !== 4'(c - 1)) begin
                    errors++; $display("FAIL b2b_idx[%0d]: got %0d want %0d", c, bus.sweep_idx, c - 1); end
            end
            bus.start = (c == 4 || c == 17);
            step();
        end
        bus.start = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_read_before_write();
        test_default_sweep();
        test_reprogram();
        test_frozen();
        test_same_edge_write_start();
        test_reset_mid_sweep();
        test_start_held();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/prog_lut_sweep.md
Name: prog_lut_sweep

Overview:
Programmable N-input truth-table (LUT) block with a built-in exhaustive sweep engine. Normal mode: registered lookup of an N-bit input vector against a writable 2^N-entry table. Sweep mode: steps through every input combination, streams each (index, output) pair and counts the minterms where f=1. Used as the reusable, parametrised successor to fixed-table combinational primitives in lab benches: the table is loaded at runtime, and self-checking replaces hand-written stimulus lists.

Parameters:
N_IN, 4, number of LUT inputs; table depth = 2^N_IN
TABLE_INIT, 16'hCAFA, reset contents of the table, bit i = f for input index i; zero-extended/truncated to 2^N_IN bits. Default encodes f=(b+d)(a'+b'+c) with {a,b,c,d}=index, a=MSB.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
in_vec  in  N_IN  lookup address, normal mode
f  out  1  registered lookup result
wr_en  in  1  table write strobe
wr_addr  in  N_IN  table write index
wr_data  in  1  table write value
start  in  1  sweep request, level-sampled in IDLE
busy  out  1  high while sweep in RUN
sweep_valid  out  1  current sweep_idx/sweep_f valid
sweep_idx  out  N_IN  current sweep index
sweep_f  out  1  table[sweep_idx]
done  out  1  one-cycle pulse after last sweep entry
ones_count  out  N_IN+1  number of table entries equal to 1 found by last sweep

Behaviour:
- Reset (rst=1 at edge): table <= TABLE_INIT; f=0; state=IDLE; busy=0; sweep_valid=0; sweep_idx=0; done=0; ones_count=0. Reset overrides every other input, including mid-sweep; no done is produced for an aborted sweep.
- Lookup: every edge, f <= table[in_vec]; latency 1 cycle. Lookup continues in all states.
- Write: at edge with wr_en=1 and state=IDLE, table[wr_addr] <= wr_data. Writes while state!=IDLE are ignored (table frozen during sweep). Same-edge lookup of wr_addr returns the old value (read-before-write); new value visible from next edge.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 at edge -> RUN, idx<=0, ones_count<=0. A start and a wr_en in the same edge: the write is performed, then the sweep sees the new contents.
  - RUN: sweep_valid=1, busy=1, sweep_idx=idx, sweep_f=table[idx] (decoded from registers). Each edge: ones_count <= ones_count + table[idx]; if idx==2^N_IN-1 -> DONE, else idx<=idx+1. No wrap of idx inside RUN.
  - DONE: done=1, busy=0, sweep_valid=0 for exactly one cycle; next edge -> IDLE unconditionally.
- start during RUN/DONE ignored. start held continuously: new sweep begins on the IDLE cycle after DONE (one idle cycle between sweeps).
- Timing: start sampled at edge E0 -> sweep_valid high for the 2^N_IN cycles after E0; done high in cycle 2^N_IN+1; ones_count final in the done cycle and held until the next start or reset.
- ones_count width N_IN+1, never overflows (max 2^N_IN).
- sweep_idx and sweep_f outside RUN: sweep_idx holds last value, sweep_f tracks table[sweep_idx]; consumers qualify with sweep_valid.

Test Plan:
- Reset: assert rst 2 cycles -> f=0, busy=0, done=0, sweep_valid=0, ones_count=0; then in_vec=4'b0001 -> f=1 next cycle; in_vec=4'b1100 -> f=0; in_vec=4'b1110 -> f=1.
- Default sweep: pulse start -> 16 consecutive sweep_valid cycles with sweep_idx 0..15 and sweep_f = 0,1,0,1,1,1,1,1,0,1,0,1,0,0,1,1; done in cycle 17; ones_count=10.
- Reprogram: in IDLE write addr 4'b1100 data 1 and addr 4'b0001 data 0, sweep -> ones_count=10; in_vec=4'b1100 -> f=1.
- Frozen table: wr_en=1, wr_addr=0, wr_data=1 asserted throughout a sweep -> sweep_f at idx 0 is 0, ones_count=10, table[0] still 0 afterwards.
- Reset mid-sweep: rst at sweep_idx=7 -> next cycle busy=0, sweep_valid=0, ones_count=0, no done pulse; table back to 16'hCAFA.
- start held high 40 cycles -> sweeps begin at cycles 1 and 19 (DONE at 17, IDLE at 18), each ends with done and ones_count=10; start pulses during RUN produce no restart.
